// File: rtl/reshuffler_pkg.sv
// Shared types for the block reshuffler: FSM state and block mode enums.
package reshuffler_pkg;

    // FILL accepts input rows, DRAIN presents output words.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Per-block operating mode, captured when the first word of a block is accepted.
    typedef enum logic {
        BYPASS    = 1'b0,
        TRANSPOSE = 1'b1
    } mode_e;

endpackage : reshuffler_pkg

// File: rtl/param_reshuffler.sv
// Block reshuffler: collects NumElems words of NumElems elements and emits the
// transposed block, or passes single words straight through in bypass mode.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   data_i        input word, element k at [k*ElemWidth +: ElemWidth]
//   data_valid_i  input word valid
//   data_ready_o  block accepts the input word (FILL state)
//   transpose_i   mode for the next block: 1 = transpose, 0 = bypass
//   data_o        output word
//   data_valid_o  output word valid (DRAIN state)
//   data_ready_i  downstream accepts the output word
//   busy_o        block holds undelivered data
module param_reshuffler
    import reshuffler_pkg::*;
#(
    parameter  int unsigned ElemWidth = 8,
    parameter  int unsigned NumElems  = 8,
    localparam int unsigned DataWidth = ElemWidth * NumElems
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic                 transpose_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 busy_o
);

    localparam int unsigned     CntW    = $clog2(NumElems);
    localparam logic [CntW-1:0] LastIdx = CntW'(NumElems - 1);

    // Reject unsupported block sizes at elaboration.
    if (NumElems < 2 || NumElems > 16) begin : g_bad_num_elems
        $error("param_reshuffler: NumElems must be within 2..16");
    end

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    mode_e                 blk_mode;
    logic [CntW-1:0]       row_q, row_d;
    logic [CntW-1:0]       col_q, col_d;
    logic                  mem_we;
    logic [CntW-1:0]       mem_addr;
    logic [DataWidth-1:0]  mem_q [NumElems];
    logic                  in_hs;
    logic                  out_hs;

    // Handshake flags; ready is held low while reset is asserted.
    assign data_ready_o = (state_q == FILL) && !rst_i;
    assign data_valid_o = (state_q == DRAIN);
    assign busy_o       = (state_q != FILL) || (row_q != '0);
    assign in_hs        = data_valid_i && data_ready_o;
    assign out_hs       = data_valid_o && data_ready_i;

    // Next-state, counter and buffer-write control.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        row_d    = row_q;
        col_d    = col_q;
        mem_we   = 1'b0;
        mem_addr = row_q;
        blk_mode = mode_q;

        case (state_q)
            FILL: begin
                if (in_hs) begin
                    // The first word of a block decides the mode for the whole block.
                    if (row_q == '0) begin
                        blk_mode = mode_e'(transpose_i);
                        mode_d   = blk_mode;
                    end
                    mem_we = 1'b1;
                    if (blk_mode == TRANSPOSE) begin
                        if (row_q == LastIdx) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + CntW'(1);
                        end
                    end else begin
                        mem_addr = '0;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (mode_q == TRANSPOSE) begin
                        if (col_q == LastIdx) begin
                            col_d   = '0;
                            state_d = FILL;
                        end else begin
                            col_d = col_q + CntW'(1);
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            mode_q  <= TRANSPOSE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Row buffer; contents are only meaningful once a row has been written.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_addr] <= data_i;
        end
    end

    // Output word: column col_q of the buffer in transpose mode, row 0 in bypass.
    always_comb begin
        data_o = mem_q[0];
        if (mode_q == TRANSPOSE) begin
            for (int unsigned r = 0; r < NumElems; r++) begin
                data_o[r*ElemWidth +: ElemWidth] = mem_q[r][col_q*ElemWidth +: ElemWidth];
            end
        end
    end

endmodule : param_reshuffler

// File: doc/param_reshuffler.md
PARAM_RESHUFFLER -- requirements
Module: param_reshuffler

Interface
REQ-001 SHALL have parameter ElemWidth, default 8: bit width of one element.
REQ-002 SHALL have parameter NumElems, default 8, legal range 2..16: elements per word, which is also words per block.
REQ-003 SHALL have derived parameter DataWidth = ElemWidth*NumElems, default 64: word width; not user-overridable.
REQ-004 SHALL have port clk_i  in  1  clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port data_i  in  DataWidth  input word; element k at bits [k*ElemWidth +: ElemWidth].
REQ-007 SHALL have port data_valid_i  in  1  input word valid.
REQ-008 SHALL have port data_ready_o  out  1  block accepts the input word.
REQ-009 SHALL have port transpose_i  in  1  mode: 1 = transpose block, 0 = bypass.
REQ-010 SHALL have port data_o  out  DataWidth  output word.
REQ-011 SHALL have port data_valid_o  out  1  output word valid.
REQ-012 SHALL have port data_ready_i  in  1  downstream accepts the output word.
REQ-013 SHALL have port busy_o  out  1  block holds undelivered data (state != FILL, or row count != 0).

Function
REQ-014 An input handshake SHALL occur when data_valid_i && data_ready_o; an output handshake SHALL occur when data_valid_o && data_ready_i.
REQ-015 The FSM SHALL have states FILL and DRAIN; data_ready_o = (state==FILL); data_valid_o = (state==DRAIN); neither output depends combinationally on data_valid_i or data_ready_i.
REQ-016 The mode SHALL be latched from transpose_i on the input handshake at row count 0; changes of transpose_i at any other time SHALL have no effect until the next block.
REQ-017 In FILL with transpose mode, input handshake r (r = 0..NumElems-1) SHALL write data_i into buffer row r and increment the row count.
REQ-018 In transpose mode, the input handshake with row count NumElems-1 SHALL reset the row count to 0 and move the FSM to DRAIN in the next cycle, so data_valid_o rises 1 cycle after the last input handshake.
REQ-019 In DRAIN with transpose mode, data_o element r SHALL equal buffer row r element c, where c is the column count (0..NumElems-1).
REQ-020 Each output handshake in transpose mode SHALL increment c; the handshake at c = NumElems-1 SHALL reset c to 0 and return the FSM to FILL.
REQ-021 In bypass mode, each input handshake SHALL store data_i in row 0 and go to DRAIN; data_o SHALL equal that word unchanged; one output handshake SHALL return the FSM to FILL.
REQ-022 In DRAIN, data_o and data_valid_o SHALL hold stable while data_ready_i is low, with no loss or duplication.
REQ-023 The buffer SHALL NOT be written in DRAIN, and input and output handshakes SHALL never occur in the same cycle.
REQ-024 Throughput SHALL be exactly 2*NumElems cycles per block in transpose mode and 2 cycles per word in bypass mode, given continuous valid and ready.
REQ-025 Counters SHALL be $clog2(NumElems) bits wide, and the wrap SHALL be explicit at NumElems-1, not by overflow.

Reset
REQ-026 Reset SHALL force state FILL, row count 0, c 0, latched mode 1, data_ready_o 0 during reset, data_valid_o 0 and busy_o 0.
REQ-027 Buffer contents SHALL NOT need reset; data_o is don't-care while data_valid_o is 0.
REQ-028 Reset asserted mid-block (in FILL or DRAIN) SHALL discard all partial data, and the first cycle after reset SHALL behave as a fresh block start.

Structure
REQ-029 Package reshuffler_pkg SHALL hold the FSM state enum (FILL, DRAIN) and the mode enum (BYPASS, TRANSPOSE).
REQ-030 The design SHALL be a single module, with the buffer as a NumElems x DataWidth register array and no sub-modules.
REQ-031 An elaboration-time assertion SHALL reject NumElems outside 2..16.

Verification (NumElems=4, ElemWidth=8)
REQ-032 Transpose: inputs 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with data_ready_i=1 SHALL produce 0x0C080400, 0x0D090501, 0x0E0A0602, 0x0F0B0703, with the first output valid 1 cycle after the 4th input handshake.
REQ-033 Backpressure: same stimulus with data_ready_i low for 3 cycles on each output SHALL hold data_o stable, keep data_ready_o=0, and deliver the identical sequence.
REQ-034 Bypass: transpose_i=0 with inputs 0xDEADBEEF, 0x12345678 SHALL produce the same two words in order, with data_ready_o high every other cycle.
REQ-035 Mode change: transpose_i toggled to 0 after the 1st input of a transpose block SHALL leave the block fully transposed, and the next block SHALL run in bypass.
REQ-036 Reset after 2 of 4 inputs SHALL give busy_o=0 next cycle, and a following full block SHALL transpose correctly with no stale rows.
REQ-037 Random valid/ready over 1000 blocks with a scoreboard SHALL show zero mismatches and a block rate of no more than 1 per 8 cycles.
